// File: rtl/aes128_iter.sv
// Iterative AES-128 encryptor: one block in flight, UNROLL rounds per clock,
// round keys expanded on the fly alongside the state.
module aes128_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
            $error("aes128_iter: UNROLL must be 1, 2, 5 or 10");
        end
    endgenerate

    localparam logic [3:0] STEP = 4'(UNROLL);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_st;
    logic [127:0] r_key;
    logic [127:0] r_dout;
    logic [127:0] w_st;
    logic [127:0] w_key;
    logic [3:0]   w_rnd;
    logic         w_accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        // ShiftRows: row r rotates left by r columns.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (last)
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            else
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o ^ rk;
    endfunction

    always_comb begin
        w_st  = r_st;
        w_key = r_key;
        w_rnd = '0;
        for (int j = 0; j < UNROLL; j++) begin
            w_rnd = r_cnt + 4'(j + 1);
            w_key = next_key(w_key, rcon(w_rnd));
            w_st  = aes_round(w_st, w_key, w_rnd == 4'd10);
        end
    end

    assign in_ready  = !rst && ((r_state == IDLE) || (r_state == DONE && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == BUSY);
    assign data_out  = r_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else if (w_accept) begin
            r_st    <= data_in ^ key_in;
            r_key   <= key_in;
            r_cnt   <= '0;
            r_state <= BUSY;
        end else if (r_state == BUSY) begin
            r_st  <= w_st;
            r_key <= w_key;
            r_cnt <= r_cnt + STEP;
            if (r_cnt + STEP == 4'd10) begin
                r_dout  <= w_st;
                r_state <= DONE;
            end
        end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
        end
    end

endmodule

// File: doc/aes128_iter.md
AES128_ITER -- requirements
Module: aes128_iter

Interface
REQ-001 The block SHALL have parameter UNROLL, default 1, meaning AES rounds computed per clock; legal values are 1, 2, 5 and 10, and any other value SHALL cause an elaboration error.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: data_in/key_in are valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a block this cycle.
REQ-006 The block SHALL have port data_in, input, 128 bits: plaintext; [127:120] is byte 0 (row 0, column 0), in FIPS-197 column-major order.
REQ-007 The block SHALL have port key_in, input, 128 bits: cipher key; [127:120] is key byte 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: data_out holds a finished ciphertext.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts data_out this cycle.
REQ-010 The block SHALL have port data_out, output, 128 bits: ciphertext, in the same byte order as data_in.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in BUSY state.

Function
REQ-012 The block SHALL implement AES-128 encryption per FIPS-197: 10 rounds, Rcon sequence 01,02,04,08,10,20,40,80,1b,36, and MixColumns omitted in round 10 only.
REQ-013 The block SHALL use states IDLE, BUSY and DONE, with state, round counter (0..10), 128-bit state register and 128-bit round-key register all registered.
REQ-014 The block SHALL drive in_ready combinationally as (state==IDLE) or (state==DONE and out_ready), and SHALL force it to 0 while rst is high.
REQ-015 On a handshake edge (in_valid and in_ready), the block SHALL load state with data_in^key_in, load the round key with key_in, clear the counter and enter BUSY; data_in/key_in are sampled only on this edge.
REQ-016 On each BUSY edge, the block SHALL apply UNROLL consecutive rounds, expanding round keys on the fly (no stored schedule), and SHALL add UNROLL to the counter.
REQ-017 On the BUSY edge where counter+UNROLL equals 10, the block SHALL write the ciphertext to data_out and enter DONE; out_valid SHALL then rise exactly 10/UNROLL edges after the acceptance edge (10, 5, 2 or 1).
REQ-018 In DONE, out_valid SHALL be 1 and data_out SHALL be held stable until the out_valid and out_ready edge.
REQ-019 On an output handshake without in_valid, the block SHALL go to IDLE, drop out_valid and hold data_out at its last value.
REQ-020 On an output handshake with in_valid in the same cycle, the block SHALL accept the new block and enter BUSY directly (back-to-back, no idle bubble).
REQ-021 The block SHALL ignore in_valid while BUSY, and in DONE while out_ready is low: no sampling and no state change.
REQ-022 The block SHALL produce a new output only after a new acceptance, never repeating or dropping an output, regardless of how long out_ready is held low.
REQ-023 The block SHALL keep busy equal to (state==BUSY) and out_valid equal to (state==DONE), both derived from registered state only.

Reset
REQ-024 When rst is high at an edge, the block SHALL set state to IDLE, counter to 0, out_valid to 0, busy to 0 and data_out to 128'h0; the internal state and key registers are don't-care.
REQ-025 Reset SHALL take priority over every handshake in the same cycle.
REQ-026 A block in flight when rst is asserted SHALL be discarded, with no out_valid pulse afterwards.
REQ-027 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-028 FIPS-197 App. B (key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734) with UNROLL=1 -> out_valid 10 edges after accept, data_out 3925841d02dc09fbdc118597196a0b32.
REQ-029 App. C.1 (key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff) for UNROLL=1,2,5,10 -> 69c4e0d86a7b0430d8cdb78070b4c55a after 10, 5, 2 and 1 edges respectively.
REQ-030 Backpressure: out_ready low for 20 cycles after out_valid, with in_valid toggling -> data_out stable, in_ready 0, and one output delivered when out_ready rises.
REQ-031 Back-to-back: App. B then App. C.1 with in_valid held and out_ready=1 -> the second block is accepted on the first block's output-handshake edge, and both ciphertexts are correct with no bubble.
REQ-032 rst pulsed at BUSY counter=4 -> no out_valid; the next App. B block after reset yields a correct result.
REQ-033 in_valid asserted while BUSY with garbage data -> the in-flight result is unaffected and the garbage is never encrypted.
